// File: rtl/prefetch_unit.sv
// Instruction prefetch buffer: issues sequential fetches, buffers in-order responses and
// hands them to decode; an execute redirect flushes the buffer and drops in-flight responses.
module prefetch_unit #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH    = 32,
   parameter int unsigned              DEPTH         = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pc_src_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic                     valid_d,
   input  logic                     ready_d,
   output logic [DATA_WIDTH-1:0]    instr_d,
   output logic [ADDRESS_WIDTH-1:0] pc_d,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_d
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [ADDRESS_WIDTH-1:0] pc_mem   [DEPTH];
   logic [DATA_WIDTH-1:0]    data_mem [DEPTH];

   logic [ADDRESS_WIDTH-1:0] fetch_pc;
   logic [PW-1:0]            alloc_ptr;
   logic [PW-1:0]            fill_ptr;
   logic [PW-1:0]            head_ptr;
   logic [CW-1:0]            occ_cnt;
   logic [CW-1:0]            pend_cnt;
   logic [CW-1:0]            drop_cnt;

   logic                     accept;
   logic                     fill;
   logic                     drop;
   logic                     pop;
   logic [CW:0]              drop_sum;
   logic [CW-1:0]            drop_flush;

   // Entries head..fill-1 hold data and fill..alloc-1 await it, so the head entry is
   // filled exactly when the allocated count exceeds the still-pending count.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      imem_req   = 1'b0;
      valid_d    = 1'b0;
      accept     = 1'b0;
      pop        = 1'b0;
      fill       = 1'b0;
      drop       = 1'b0;
      drop_sum   = '0;
      drop_flush = '0;
      instr_d    = '0;
      pc_d       = '0;
      pc_plus4_d = '0;

      imem_req = !pc_src_e && (({1'b0, occ_cnt} + {1'b0, drop_cnt}) < (CW+1)'(DEPTH));
      valid_d  = !pc_src_e && (occ_cnt != pend_cnt);
      accept   = imem_req && imem_gnt;
      pop      = valid_d && ready_d;
      fill     = imem_rvalid && !pc_src_e && (drop_cnt == '0) && (pend_cnt != '0);
      drop     = imem_rvalid && !pc_src_e && (drop_cnt != '0);

      // A response arriving with the redirect belongs to the oldest abandoned request.
      drop_sum   = {1'b0, drop_cnt} + {1'b0, pend_cnt};
      drop_flush = CW'(drop_sum - (CW+1)'(imem_rvalid && (drop_sum != '0)));

      if (valid_d) begin
         instr_d    = data_mem[head_ptr];
         pc_d       = pc_mem[head_ptr];
         pc_plus4_d = pc_mem[head_ptr] + ADDRESS_WIDTH'(4);
      end
   end

   assign imem_addr = fetch_pc;

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state is updated only with non-blocking assignments.
      if (!rst) begin
         fetch_pc  <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         occ_cnt   <= '0;
         pend_cnt  <= '0;
         drop_cnt  <= '0;
      end else if (pc_src_e) begin
         fetch_pc  <= pc_target_e;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         occ_cnt   <= '0;
         pend_cnt  <= '0;
         drop_cnt  <= drop_flush;
      end else begin
         if (accept) begin
            alloc_ptr <= alloc_ptr + PW'(1);
            fetch_pc  <= fetch_pc + ADDRESS_WIDTH'(4);
         end
         if (fill) begin
            fill_ptr <= fill_ptr + PW'(1);
         end
         if (pop) begin
            head_ptr <= head_ptr + PW'(1);
         end
         if (drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         occ_cnt  <= occ_cnt + CW'(accept) - CW'(pop);
         pend_cnt <= pend_cnt + CW'(accept) - CW'(fill);
      end
   end

   // NOTE: the entry storage is deliberately not reset; the counters alone decide validity.
   always_ff @(posedge clk) begin
      if (accept) begin
         pc_mem[alloc_ptr] <= fetch_pc;
      end
      if (fill) begin
         data_mem[fill_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_prefetch_unit.sv
// Testbench for prefetch_unit: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the fetch/response/decode flow.
module tb_prefetch_unit;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          pc_src_e;
   logic [AW-1:0] pc_target_e;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          ready_d;

   logic          n_req, n_valid, w_req, w_valid;
   logic [AW-1:0] n_addr, n_pc, n_pc4, w_addr, w_pc, w_pc4;
   logic [DW-1:0] n_instr, w_instr;

   logic          sel;
   logic          obs_req, obs_valid;
   logic [AW-1:0] obs_addr, obs_pc, obs_pc4;
   logic [DW-1:0] obs_instr;

   always #5 clk = ~clk;

   prefetch_unit #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
   ) dut (
      .clk(clk), .rst(rst), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
      .imem_req(n_req), .imem_addr(n_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .valid_d(n_valid), .ready_d(ready_d), .instr_d(n_instr), .pc_d(n_pc),
      .pc_plus4_d(n_pc4)
   );

   prefetch_unit #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)
   ) dut_w (
      .clk(clk), .rst(rst), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .valid_d(w_valid), .ready_d(ready_d), .instr_d(w_instr), .pc_d(w_pc),
      .pc_plus4_d(w_pc4)
   );

   assign obs_req   = sel ? w_req   : n_req;
   assign obs_addr  = sel ? w_addr  : n_addr;
   assign obs_valid = sel ? w_valid : n_valid;
   assign obs_instr = sel ? w_instr : n_instr;
   assign obs_pc    = sel ? w_pc    : n_pc;
   assign obs_pc4   = sel ? w_pc4   : n_pc4;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } ent_t;

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
      logic [AW-1:0] pc4;
      int            cyc;
   } dlv_t;

   int            nchk = 0;
   int            nerr = 0;
   int            cyc;
   int            gnt_cnt;
   logic [AW-1:0] cur_rst_pc;

   // Reference model: next fetch address, requests still owed data, buffered
   // instructions awaiting decode, and responses still to be thrown away.
   logic [AW-1:0] m_pc;
   int            m_drop;
   logic [AW-1:0] m_infl[$];
   ent_t          m_ready[$];

   // Memory environment: grant cycle of every request not yet answered.
   int            env_q[$];
   dlv_t          delivered[$];
   logic [DW-1:0] resp_log[$];
   logic          rlog_en;

   // rmode: 0 no response, 1 respond when legal, 2 respond randomly, 3 force rvalid.
   task automatic step(input logic src, input logic [AW-1:0] tgt, input logic gnt,
                       input int rmode, input logic rdy);
      logic          exp_req, exp_valid, rv;
      logic [AW-1:0] exp_pc, exp_pc4;
      logic [DW-1:0] exp_instr, rd;
      ent_t          e;
      dlv_t          d;
      rv = 1'b0;
      if (rmode == 3) rv = 1'b1;
      else if (env_q.size() > 0 && env_q[0] < cyc)
         rv = (rmode == 1) || (rmode == 2 && $urandom_range(0, 1) == 1);
      rd          = $urandom;
      pc_src_e    = src;
      pc_target_e = tgt;
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rd;
      ready_d     = rdy;
      @(negedge clk);
      exp_req   = !src && (m_infl.size() + m_ready.size() + m_drop < DEPTH);
      exp_valid = !src && (m_ready.size() > 0);
      exp_pc    = '0;
      exp_pc4   = '0;
      exp_instr = '0;
      if (exp_valid) begin
         exp_pc    = m_ready[0].pc;
         exp_pc4   = m_ready[0].pc + 32'd4;
         exp_instr = m_ready[0].instr;
      end
      nchk++;
      if (obs_req !== exp_req) begin
         nerr++;
         $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, obs_req, exp_req);
      end
      nchk++;
      if (obs_addr !== m_pc) begin
         nerr++;
         $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, m_pc);
      end
      nchk++;
      if (obs_valid !== exp_valid) begin
         nerr++;
         $display("FAIL valid_d cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid);
      end
      nchk++;
      if (obs_pc !== exp_pc || obs_pc4 !== exp_pc4) begin
         nerr++;
         $display("FAIL pc_d cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_pc, obs_pc4, exp_pc, exp_pc4);
      end
      nchk++;
      if (obs_instr !== exp_instr) begin
         nerr++;
         $display("FAIL instr_d cyc=%0d got=%h exp=%h", cyc, obs_instr, exp_instr);
      end
      if (obs_valid === 1'b1 && rdy) begin
         d.pc = obs_pc; d.instr = obs_instr; d.pc4 = obs_pc4; d.cyc = cyc;
         delivered.push_back(d);
      end
      if (obs_req === 1'b1 && gnt) gnt_cnt++;
      if (rlog_en && rv) resp_log.push_back(rd);
      if (src) begin
         m_drop += m_infl.size();
         if (rv && m_drop > 0) m_drop--;
         m_infl.delete();
         m_ready.delete();
         m_pc = tgt;
      end else begin
         if (exp_valid && rdy) void'(m_ready.pop_front());
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else if (m_infl.size() > 0) begin
               e.pc    = m_infl.pop_front();
               e.instr = rd;
               m_ready.push_back(e);
            end
         end
         if (exp_req && gnt) begin
            m_infl.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      if (rv && env_q.size() > 0) void'(env_q.pop_front());
      if (exp_req && gnt) env_q.push_back(cyc);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input logic [AW-1:0] rpc);
      rst         = 1'b0;
      pc_src_e    = 1'b0;
      pc_target_e = '0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      ready_d     = 1'b0;
      @(posedge clk);
      #1;
      cur_rst_pc = rpc;
      m_pc       = rpc;
      m_drop     = 0;
      m_infl.delete();
      m_ready.delete();
      env_q.delete();
      delivered.delete();
      resp_log.delete();
      rlog_en = 1'b0;
      cyc     = 0;
      gnt_cnt = 0;
      rst     = 1'b1;
   endtask

   task automatic check_pcs(input string name, input logic [AW-1:0] exp_pcs[4]);
      logic [AW-1:0] got;
      for (int i = 0; i < 4; i++) begin
         got = (i < delivered.size()) ? delivered[i].pc : 'x;
         nchk++;
         if (got !== exp_pcs[i]) begin
            nerr++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, i, got, exp_pcs[i]);
         end
      end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      rst = 1'b0;
      pc_src_e = 1'b0; pc_target_e = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; ready_d = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nchk++;
      if (obs_valid !== 1'b0 || obs_instr !== '0 || obs_pc !== '0 || obs_pc4 !== '0) begin
         nerr++;
         $display("FAIL reset_outputs got=%b/%h/%h/%h exp=0/0/0/0", obs_valid, obs_instr, obs_pc, obs_pc4);
      end
      nchk++;
      if (obs_addr !== 32'h0) begin
         nerr++;
         $display("FAIL reset_addr got=%h exp=%h", obs_addr, 32'h0);
      end
      do_reset(32'h0);
      #1;
      nchk++;
      if (obs_req !== 1'b1) begin
         nerr++;
         $display("FAIL req_after_reset got=%b exp=1", obs_req);
      end
   endtask

   task automatic test_streaming();
      logic [AW-1:0] exp_pcs[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset(32'h0);
      repeat (8) step(1'b0, '0, 1'b1, 1, 1'b1);
      check_pcs("stream_pc", exp_pcs);
      for (int i = 0; i < 4; i++) begin
         nchk++;
         if (i >= delivered.size() || delivered[i].cyc != 2 + i) begin
            nerr++;
            $display("FAIL stream_cycle[%0d] got=%0d exp=%0d", i,
                     (i < delivered.size()) ? delivered[i].cyc : -1, 2 + i);
         end
      end
   endtask

   task automatic test_stall();
      logic [AW-1:0] exp_pcs[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset(32'h0);
      repeat (10) step(1'b0, '0, 1'b1, 1, 1'b0);
      nchk++;
      if (gnt_cnt != 4) begin
         nerr++;
         $display("FAIL stall_grants got=%0d exp=4", gnt_cnt);
      end
      nchk++;
      if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
         nerr++;
         $display("FAIL stall_hold got=req%b/valid%b/pc%h exp=req0/valid1/pc0", obs_req, obs_valid, obs_pc);
      end
      delivered.delete();
      repeat (6) step(1'b0, '0, 1'b1, 1, 1'b1);
      check_pcs("stall_release_pc", exp_pcs);
   endtask

   task automatic test_flush_outstanding();
      do_reset(32'h0);
      repeat (3) step(1'b0, '0, 1'b1, 0, 1'b1);
      step(1'b1, 32'h100, 1'b1, 0, 1'b1);
      delivered.delete();
      rlog_en = 1'b1;
      repeat (10) step(1'b0, '0, 1'b1, 1, 1'b1);
      nchk++;
      if (delivered.size() == 0 || resp_log.size() < 4 ||
          delivered[0].pc !== 32'h100 || delivered[0].instr !== resp_log[3]) begin
         nerr++;
         $display("FAIL flush3_first got=pc%h/instr%h exp=pc100/instr%h",
                  (delivered.size() > 0) ? delivered[0].pc : 'x,
                  (delivered.size() > 0) ? delivered[0].instr : 'x,
                  (resp_log.size() > 3) ? resp_log[3] : 'x);
      end
   endtask

   task automatic test_flush_with_rvalid();
      do_reset(32'h0);
      repeat (2) step(1'b0, '0, 1'b1, 0, 1'b1);
      step(1'b1, 32'h200, 1'b1, 1, 1'b1);
      delivered.delete();
      rlog_en = 1'b1;
      repeat (8) step(1'b0, '0, 1'b1, 1, 1'b1);
      nchk++;
      if (delivered.size() == 0 || resp_log.size() < 2 ||
          delivered[0].pc !== 32'h200 || delivered[0].instr !== resp_log[1]) begin
         nerr++;
         $display("FAIL flush_rvalid_first got=pc%h/instr%h exp=pc200/instr%h",
                  (delivered.size() > 0) ? delivered[0].pc : 'x,
                  (delivered.size() > 0) ? delivered[0].instr : 'x,
                  (resp_log.size() > 1) ? resp_log[1] : 'x);
      end
   endtask

   task automatic test_spurious_rvalid();
      logic [AW-1:0] exp_pcs[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset(32'h0);
      repeat (3) step(1'b0, '0, 1'b0, 3, 1'b1);
      nchk++;
      if (obs_valid !== 1'b0 || obs_addr !== 32'h0) begin
         nerr++;
         $display("FAIL spurious_ignored got=valid%b/addr%h exp=valid0/addr0", obs_valid, obs_addr);
      end
      repeat (8) step(1'b0, '0, 1'b1, 1, 1'b1);
      check_pcs("spurious_stream_pc", exp_pcs);
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_pcs[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      sel = 1'b1;
      do_reset(32'hFFFF_FFF8);
      repeat (8) step(1'b0, '0, 1'b1, 1, 1'b1);
      check_pcs("wrap_pc", exp_pcs);
      nchk++;
      if (delivered.size() < 2 || delivered[1].pc4 !== 32'h0) begin
         nerr++;
         $display("FAIL wrap_pc_plus4 got=%h exp=%h",
                  (delivered.size() > 1) ? delivered[1].pc4 : 'x, 32'h0);
      end
      sel = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [AW-1:0] exp_pcs[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset(32'h0);
      repeat (6) step(1'b0, '0, 1'b1, 1, 1'b1);
      nchk++;
      if (obs_valid !== 1'b1 || obs_addr === 32'h0) begin
         nerr++;
         $display("FAIL async_pre got=valid%b/addr%h exp=valid1/addr!=0", obs_valid, obs_addr);
      end
      #2;
      rst = 1'b0;
      #1;
      nchk++;
      if (obs_valid !== 1'b0 || obs_addr !== cur_rst_pc || obs_pc !== '0 || obs_instr !== '0) begin
         nerr++;
         $display("FAIL async_reset got=valid%b/addr%h/pc%h/instr%h exp=valid0/addr%h/pc0/instr0",
                  obs_valid, obs_addr, obs_pc, obs_instr, cur_rst_pc);
      end
      @(posedge clk);
      #1;
      do_reset(32'h0);
      repeat (8) step(1'b0, '0, 1'b1, 1, 1'b1);
      check_pcs("async_restart_pc", exp_pcs);
   endtask

   task automatic test_random();
      logic          src;
      logic [AW-1:0] tgt;
      do_reset(32'h0);
      for (int i = 0; i < 3000; i++) begin
         src      = ($urandom_range(0, 29) == 0);
         tgt      = $urandom;
         tgt[1:0] = 2'b00;
         step(src, tgt, ($urandom_range(0, 3) != 0), 2, ($urandom_range(0, 2) != 0));
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall();
      test_flush_outstanding();
      test_flush_with_rvalid();
      test_spurious_rvalid();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
